// File: rtl/ptl_arb_pkg.sv
// Shared definitions for the PTL link arbiter family.
//   arb_state_t     : arbiter FSM encoding (IDLE/FIRE/HOLD)
//   INFLIGHT_W      : width of the unacknowledged-pulse counter
//   PTL_ARB_RANGE_CHECK(lbl, val, lo, hi) : elaboration-time parameter guard,
//                     used at module scope; stops elaboration when out of range.
`ifndef PTL_ARB_RANGE_CHECK
`define PTL_ARB_RANGE_CHECK(lbl, val, lo, hi) \
  if (((val) < (lo)) || ((val) > (hi))) begin : lbl \
    $error("ptl_link_arbiter: parameter out of range"); \
  end
`endif

package ptl_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

  localparam int INFLIGHT_W = 4;

endpackage

// File: rtl/ptl_link_arbiter_if.sv
// Request/grant/launch bundle between the requesters, the arbiter and the
// PTL driver/receiver.
//   req      : per-requester level request (held until granted)
//   rx_ack   : one-cycle pulse, a pulse arrived at the link receiver
//   gnt      : one-hot grant, only during the launch cycle
//   gnt_idx  : granted index, driver mux select
//   ptl_fire : one-cycle launch strobe
// master = arbiter side, slave = requester/link side.
interface ptl_link_arbiter_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic          rx_ack;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          ptl_fire;

  modport master (input req, rx_ack, output gnt, gnt_idx, ptl_fire);
  modport slave  (output req, rx_ack, input gnt, gnt_idx, ptl_fire);
endinterface

// File: rtl/ptl_link_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted req at index >= ptr,
// wrapping modulo N.
//   req    : request vector
//   ptr    : starting index (highest priority)
//   any    : at least one request asserted
//   winner : selected index (0 when any==0)
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] winner
);

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        any    = 1'b1;
        winner = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/ptl_link_arbiter.sv
// Shares one single-pulse PTL link between N requesters. Round-robin grant,
// one pulse per grant, minimum SPACING cycles between pulses, at most
// MAX_INFLIGHT unacknowledged pulses, watchdog on missing receiver acks.
//   clk, rst_n     : clock, async active-low reset
//   en             : arbitration enable (gates only the IDLE decision)
//   err_clr        : clears the sticky error flags
//   bus            : req/rx_ack in, gnt/gnt_idx/ptl_fire out
//   inflight       : unacknowledged pulse count
//   busy           : FSM active or pulses outstanding
//   err_underflow  : sticky, rx_ack with nothing in flight
//   err_timeout    : sticky, no rx_ack for TIMEOUT cycles while in flight
module ptl_link_arbiter
  import ptl_arb_pkg::*;
#(
  parameter int N            = 4,
  parameter int SPACING      = 3,
  parameter int MAX_INFLIGHT = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  err_clr,
  ptl_link_arbiter_if.master    bus,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic                  busy,
  output logic                  err_underflow,
  output logic                  err_timeout
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(SPACING);
  localparam int WW = $clog2(TIMEOUT);

  `PTL_ARB_RANGE_CHECK(chk_n, N, 2, 16)
  `PTL_ARB_RANGE_CHECK(chk_spacing, SPACING, 2, 65535)
  `PTL_ARB_RANGE_CHECK(chk_inflight, MAX_INFLIGHT, 1, 15)
  `PTL_ARB_RANGE_CHECK(chk_timeout, TIMEOUT, 2, 65535)

  arb_state_t    state, state_nxt;
  logic [IW-1:0] win, win_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [WW-1:0] wdog, wdog_nxt;
  logic [INFLIGHT_W-1:0] infl_nxt;
  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          fire, ack, uf_evt, to_evt;

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .any    (pick_any),
    .winner (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      win      <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      win      <= win_nxt;
      rr_ptr   <= rr_ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Winner is latched on leaving IDLE so a req drop during FIRE cannot
  // cancel the launch.
  always_comb begin
    state_nxt  = state;
    win_nxt    = win;
    rr_ptr_nxt = rr_ptr;
    hold_nxt   = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (en && pick_any && (int'(inflight) < MAX_INFLIGHT)) begin
          win_nxt   = pick_idx;
          state_nxt = ST_FIRE;
        end
      end
      ST_FIRE: begin
        rr_ptr_nxt = (win == IW'(N - 1)) ? '0 : win + 1'b1;
        if (SPACING > 2) begin
          state_nxt = ST_HOLD;
          hold_nxt  = HW'(SPACING - 2);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt <= HW'(1)) state_nxt = ST_IDLE;
        else                    hold_nxt  = hold_cnt - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fire         = (state == ST_FIRE);
    bus.ptl_fire = fire;
    bus.gnt      = fire ? (N'(1) << win) : '0;
    bus.gnt_idx  = fire ? win : '0;
    busy         = (state != ST_IDLE) || (inflight != '0);
  end

  // Credit and watchdog. A timeout discards all outstanding pulses, but a
  // launch in the same cycle still counts as one new pulse in flight.
  always_comb begin
    ack    = bus.rx_ack;
    uf_evt = ack && !fire && (inflight == '0);
    to_evt = (inflight != '0) && !ack && (wdog == WW'(TIMEOUT - 1));

    infl_nxt = inflight;
    if (fire && !ack)                          infl_nxt = inflight + 1'b1;
    else if (ack && !fire && inflight != '0)   infl_nxt = inflight - 1'b1;
    if (to_evt) infl_nxt = fire ? INFLIGHT_W'(1) : '0;

    if ((inflight == '0) || ack || to_evt) wdog_nxt = '0;
    else                                   wdog_nxt = wdog + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= '0;
      wdog          <= '0;
      err_underflow <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      inflight      <= infl_nxt;
      wdog          <= wdog_nxt;
      err_underflow <= uf_evt || (err_underflow && !err_clr);
      err_timeout   <= to_evt || (err_timeout && !err_clr);
    end
  end

endmodule

// File: tb/tb_ptl_link_arbiter.sv
module tb_ptl_link_arbiter;
  localparam int N       = 4;
  localparam int SPACING = 3;
  localparam int MAXI    = 2;
  localparam int TMO     = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       err_clr;
  logic [3:0] inflight;
  logic       busy;
  logic       err_underflow;
  logic       err_timeout;

  int vectors = 0;
  int miscompares = 0;

  ptl_link_arbiter_if #(.N(N)) bus ();

  ptl_link_arbiter #(
    .N(N), .SPACING(SPACING), .MAX_INFLIGHT(MAXI), .TIMEOUT(TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .err_clr       (err_clr),
    .bus           (bus),
    .inflight      (inflight),
    .busy          (busy),
    .err_underflow (err_underflow),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    en = 1'b0;
    err_clr = 1'b0;
    bus.req = '0;
    bus.rx_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    vectors++;
    if ({bus.ptl_fire, bus.gnt, bus.gnt_idx} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_grant: got fire=%0b gnt=%b idx=%0d, expected all 0",
               bus.ptl_fire, bus.gnt, bus.gnt_idx);
    end
    vectors++;
    if ({inflight, busy, err_underflow, err_timeout} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_status: got infl=%0d busy=%0b uf=%0b to=%0b, expected all 0",
               inflight, busy, err_underflow, err_timeout);
    end
  endtask

  task automatic test_single;
    do_reset();
    en = 1'b1;
    bus.req = 4'b0100;
    tick();
    vectors++;
    if ({bus.ptl_fire, bus.gnt, bus.gnt_idx} !== {1'b1, 4'b0100, 2'd2}) begin
      miscompares++;
      $display("FAIL single_fire: got fire=%0b gnt=%b idx=%0d, expected 1 0100 2",
               bus.ptl_fire, bus.gnt, bus.gnt_idx);
    end
    bus.req = '0;
    tick();
    vectors++;
    if (inflight !== 4'd1) begin
      miscompares++;
      $display("FAIL single_inflight: got %0d expected 1", inflight);
    end
    tick();
    tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_busy_held: got %0b expected 1", busy);
    end
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    vectors++;
    if ({inflight, busy} !== {4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_ack: got infl=%0d busy=%0b expected 0 0", inflight, busy);
    end
  endtask

  task automatic test_round_robin;
    int n = 0;
    int last = -1;
    logic prev_fire = 1'b0;
    do_reset();
    en = 1'b1;
    bus.req = 4'b1111;
    for (int t = 1; t <= 16; t++) begin
      tick();
      bus.rx_ack = prev_fire;
      prev_fire = bus.ptl_fire;
      if (bus.ptl_fire) begin
        vectors++;
        if (int'(bus.gnt_idx) !== (n % N)) begin
          miscompares++;
          $display("FAIL rr_order: fire %0d got idx=%0d expected %0d", n, bus.gnt_idx, n % N);
        end
        vectors++;
        if ((n == 0 && t != 1) || (n > 0 && (t - last) != SPACING)) begin
          miscompares++;
          $display("FAIL rr_spacing: fire %0d at cycle %0d, previous %0d, expected gap %0d",
                   n, t, last, SPACING);
        end
        last = t;
        n++;
      end
    end
    bus.rx_ack = 1'b0;
    bus.req = '0;
    vectors++;
    if (n != 6) begin
      miscompares++;
      $display("FAIL rr_count: got %0d fires expected 6", n);
    end
  endtask

  task automatic test_credit;
    int fires = 0;
    do_reset();
    en = 1'b1;
    bus.req = 4'b0011;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (bus.ptl_fire) fires++;
    end
    vectors++;
    if (fires != 2 || inflight !== 4'd2) begin
      miscompares++;
      $display("FAIL credit_stall: got fires=%0d infl=%0d expected 2 2", fires, inflight);
    end
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    vectors++;
    if ({bus.ptl_fire, inflight} !== {1'b0, 4'd1}) begin
      miscompares++;
      $display("FAIL credit_decide: got fire=%0b infl=%0d expected 0 1", bus.ptl_fire, inflight);
    end
    tick();
    vectors++;
    if ({bus.ptl_fire, bus.gnt_idx} !== {1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL credit_resume: got fire=%0b idx=%0d expected 1 0", bus.ptl_fire, bus.gnt_idx);
    end
    bus.req = '0;
  endtask

  task automatic test_fire_ack_underflow;
    do_reset();
    en = 1'b1;
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    tick();
    tick();
    bus.req = 4'b0010;
    tick();
    vectors++;
    if ({bus.ptl_fire, inflight} !== {1'b1, 4'd1}) begin
      miscompares++;
      $display("FAIL fa_setup: got fire=%0b infl=%0d expected 1 1", bus.ptl_fire, inflight);
    end
    bus.req = '0;
    bus.rx_ack = 1'b1;
    tick();
    vectors++;
    if ({inflight, err_underflow} !== {4'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL fire_and_ack: got infl=%0d uf=%0b expected 1 0", inflight, err_underflow);
    end
    tick();
    vectors++;
    if ({inflight, err_underflow} !== {4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL ack_to_zero: got infl=%0d uf=%0b expected 0 0", inflight, err_underflow);
    end
    tick();
    bus.rx_ack = 1'b0;
    vectors++;
    if ({inflight, err_underflow} !== {4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL underflow: got infl=%0d uf=%0b expected 0 1", inflight, err_underflow);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if (err_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL uf_clear: got %0b expected 0", err_underflow);
    end
    bus.rx_ack = 1'b1;
    tick();
    err_clr = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    vectors++;
    if (err_underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL uf_event_wins: got %0b expected 1", err_underflow);
    end
    tick();
    err_clr = 1'b0;
    vectors++;
    if (err_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL uf_clear2: got %0b expected 0", err_underflow);
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    do_reset();
    en = 1'b1;
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    while (!err_timeout && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (n != TMO + 1) begin
      miscompares++;
      $display("FAIL timeout_latency: flag after %0d cycles expected %0d", n, TMO + 1);
    end
    vectors++;
    if ({inflight, busy} !== {4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL timeout_flush: got infl=%0d busy=%0b expected 0 0", inflight, busy);
    end
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    vectors++;
    if ({bus.ptl_fire, bus.gnt_idx, err_timeout} !== {1'b1, 2'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL timeout_resume: got fire=%0b idx=%0d to=%0b expected 1 1 1",
               bus.ptl_fire, bus.gnt_idx, err_timeout);
    end
  endtask

  task automatic test_en_drop;
    int fires = 0;
    do_reset();
    en = 1'b1;
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0010;
    en = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (bus.ptl_fire) fires++;
    end
    vectors++;
    if (fires != 0 || inflight !== 4'd1) begin
      miscompares++;
      $display("FAIL en_block: got fires=%0d infl=%0d expected 0 1", fires, inflight);
    end
    en = 1'b1;
    tick();
    bus.req = '0;
    vectors++;
    if ({bus.ptl_fire, bus.gnt} !== {1'b1, 4'b0010}) begin
      miscompares++;
      $display("FAIL en_resume: got fire=%0b gnt=%b expected 1 0010", bus.ptl_fire, bus.gnt);
    end
  endtask

  task automatic test_reset_mid_fire;
    do_reset();
    en = 1'b1;
    bus.req = 4'b1000;
    tick();
    vectors++;
    if (bus.ptl_fire !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_setup: got fire=%0b expected 1", bus.ptl_fire);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.ptl_fire, bus.gnt, busy} !== 6'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: got fire=%0b gnt=%b busy=%0b expected 0",
               bus.ptl_fire, bus.gnt, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req = 4'b1111;
    tick();
    bus.req = '0;
    vectors++;
    if ({bus.ptl_fire, bus.gnt, inflight} !== {1'b1, 4'b0001, 4'd0}) begin
      miscompares++;
      $display("FAIL rstmid_ptr: got fire=%0b gnt=%b infl=%0d expected 1 0001 0",
               bus.ptl_fire, bus.gnt, inflight);
    end
  endtask

  // Reference model: time-based. A grant decision is possible on any cycle at
  // least SPACING-1 cycles after the previous launch with no launch pending;
  // inflight is launches minus acks; the watchdog is a run-length of quiet
  // cycles with pulses outstanding.
  task automatic test_random(input int ncyc);
    bit pend = 1'b0;
    int mwin = 0, mptr = 0, mlast = -100, minfl = 0, mquiet = 0;
    bit muf = 1'b0, mto = 1'b0;
    logic [N-1:0] rq = '0, gprev = '0, e_gnt;
    logic [1:0] e_idx;
    bit e_busy, ack, clr, en_r, fire, idle, found, uf_ev, to_ev;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      e_gnt = '0;
      if (pend) e_gnt[mwin] = 1'b1;
      e_idx = pend ? 2'(mwin) : 2'd0;
      e_busy = pend || (c <= mlast + SPACING - 2) || (minfl != 0);
      vectors++;
      if ({bus.ptl_fire, bus.gnt, bus.gnt_idx, inflight, busy, err_underflow, err_timeout}
          !== {pend, e_gnt, e_idx, 4'(minfl), e_busy, muf, mto}) begin
        miscompares++;
        $display("FAIL random c=%0d: got fire=%0b gnt=%b idx=%0d infl=%0d busy=%0b uf=%0b to=%0b; expected %0b %b %0d %0d %0b %0b %0b",
                 c, bus.ptl_fire, bus.gnt, bus.gnt_idx, inflight, busy, err_underflow,
                 err_timeout, pend, e_gnt, e_idx, minfl, e_busy, muf, mto);
      end
      for (int i = 0; i < N; i++) begin
        if (gprev[i])     rq[i] = 1'b0;
        else if (rq[i])   begin if ($urandom_range(49) == 0) rq[i] = 1'b0; end
        else if ($urandom_range(3) == 0) rq[i] = 1'b1;
      end
      en_r = ($urandom_range(9) != 0);
      if (((c / 400) % 3) == 2) ack = 1'b0;
      else if (minfl > 0)       ack = ($urandom_range(2) == 0);
      else                      ack = ($urandom_range(49) == 0);
      clr = ($urandom_range(19) == 0);
      bus.req = rq;
      bus.rx_ack = ack;
      en = en_r;
      err_clr = clr;

      fire = pend;
      idle = !pend && (c >= mlast + SPACING - 1);
      if (fire) begin
        mptr = (mwin + 1) % N;
        mlast = c;
      end
      pend = 1'b0;
      if (idle && en_r && (rq != '0) && (minfl < MAXI)) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && rq[(mptr + k) % N]) begin
            mwin = (mptr + k) % N;
            found = 1'b1;
          end
        end
        pend = 1'b1;
      end
      uf_ev = ack && !fire && (minfl == 0);
      to_ev = 1'b0;
      if (minfl > 0 && !ack) begin
        mquiet++;
        if (mquiet == TMO) begin
          to_ev = 1'b1;
          mquiet = 0;
        end
      end else begin
        mquiet = 0;
      end
      minfl = minfl + int'(fire) - int'(ack);
      if (minfl < 0) minfl = 0;
      if (to_ev) minfl = int'(fire);
      muf = uf_ev || (muf && !clr);
      mto = to_ev || (mto && !clr);
      gprev = e_gnt;
      tick();
    end
    bus.req = '0;
    bus.rx_ack = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credit();
    test_fire_ack_underflow();
    test_timeout();
    test_en_drop();
    test_reset_mid_fire();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
